// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
//   imem_req   : fetch request, held with imem_addr until imem_ack
//   imem_addr  : word-aligned fetch byte address
//   imem_ack   : read data valid this cycle
//   imem_rdata : fetched word, bit 0 is the MSB
// Modports: master = fetch stage, slave = instruction memory.
interface if_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [0:31] imem_rdata;

  modport master (output imem_req, output imem_addr,
                  input  imem_ack, input  imem_rdata);
  modport slave  (input  imem_req, input  imem_addr,
                  output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage. Owns the architectural PC, fetches one word at a
// time over the imem bus, holds it for decode and computes the next PC from
// decode's jump/branch outputs. A misaligned redirect target halts fetching
// and raises a sticky fault until reset.
// Ports:
//   clk, reset            : clock (rising edge), async active-low reset
//   stall                 : downstream hold, freezes held instruction and PC
//   branch, branch_taken  : conditional branch for the held instruction
//   jump, jump_reg        : PC-relative jump / register jump
//   reg_target            : register jump target
//   imem                  : fetch bus (master side)
//   instruction, instr_valid, pc, pc_plus4 : held instruction and its address
//   fetch_fault           : sticky misaligned-target flag
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall,
  input  logic           branch,
  input  logic           branch_taken,
  input  logic           jump,
  input  logic           jump_reg,
  input  logic [31:0]    reg_target,
  if_stage_if.master     imem,
  output logic [0:31]    instruction,
  output logic           instr_valid,
  output logic [31:0]    pc,
  output logic [31:0]    pc_plus4,
  output logic           fetch_fault
);

  typedef enum logic [1:0] {IDLE, REQ, EXEC, HALT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pc_q, pc_d;
  logic [0:31] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;

  logic [31:0] jump_off;
  logic [31:0] br_off;
  logic [31:0] next_pc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    valid_d    = valid_q;
    fault_d    = fault_q;

    pc_plus4 = pc_q + 32'd4;
    // Bit 31 is the LSB, so [6:31] / [16:31] are the low 26 / 16 bits and
    // bit 6 / bit 16 carry the sign.
    jump_off = {{6{instr_q[6]}}, instr_q[6:31]};
    br_off   = {{16{instr_q[16]}}, instr_q[16:31]};

    if (jump_reg)                  next_pc = reg_target;
    else if (jump)                 next_pc = pc_plus4 + jump_off;
    else if (branch && branch_taken) next_pc = pc_plus4 + br_off;
    else                           next_pc = pc_plus4;

    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          pc_d    = fetch_pc_q;
          valid_d = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!stall) begin
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = HALT;
          end else begin
            fetch_pc_d = next_pc;
            state_d    = REQ;
          end
        end
      end
      HALT: valid_d = 1'b0;
    endcase
  end

  // Request is decoded from the state register so an async reset drops it
  // in the same cycle.
  assign imem.imem_req  = (state_q == REQ);
  assign imem.imem_addr = fetch_pc_q;
  assign instruction    = instr_q;
  assign instr_valid    = valid_q;
  assign pc             = pc_q;
  assign fetch_fault    = fault_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: stimulus pushes expected fetch addresses and
// expected held instructions; a negedge monitor pops and compares them.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, branch, branch_taken, jump, jump_reg;
  logic [31:0] reg_target;
  logic [0:31] instruction;
  logic        instr_valid;
  logic [31:0] pc, pc_plus4;
  logic        fetch_fault;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch),
    .branch_taken(branch_taken), .jump(jump), .jump_reg(jump_reg),
    .reg_target(reg_target), .imem(bus), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] ins; } exp_t;
  logic [31:0] exp_addr_q[$];
  exp_t        exp_ins_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_hs = -1;
  logic period_chk = 1'b0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: fetch handshakes and newly presented instructions.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (bus.imem_req && bus.imem_ack) begin
        if (exp_addr_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_fetch: got addr %h expected none", bus.imem_addr);
        end else begin
          chk("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
        end
        if (period_chk && last_hs >= 0) chk("fetch_period", cyc - last_hs, 2);
        last_hs = cyc;
      end
      if (instr_valid && !prev_valid) begin
        if (exp_ins_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL unexpected_instr: got pc %h expected none", pc);
        end else begin
          exp_t e;
          e = exp_ins_q.pop_front();
          chk("held_pc", pc, e.pc);
          chk("held_instr", instruction, e.ins);
          chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
      end
      prev_valid = instr_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic wait_req();
    int n = 0;
    while (bus.imem_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bus.imem_req !== 1'b1) begin
      n_checks++; n_errors++;
      $display("FAIL req_timeout: got imem_req %b expected 1 within 20 cycles", bus.imem_req);
    end
  endtask

  task automatic serve(input int lat, input logic [31:0] data, input logic [31:0] addr);
    exp_t e;
    e.pc = addr; e.ins = data;
    exp_addr_q.push_back(addr);
    exp_ins_q.push_back(e);
    wait_req();
    for (int i = 0; i < lat; i++) begin
      bus.imem_ack = 1'b0;
      @(posedge clk); #1;
      chk("req_hold", {31'b0, bus.imem_req}, 32'd1);
      chk("addr_hold", bus.imem_addr, addr);
    end
    chk("valid_before_ack", {31'b0, instr_valid}, 32'd0);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = data;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk("instr_after_ack", instruction, data);
  endtask

  task automatic exec(input logic b, input logic bt, input logic j, input logic jr,
                      input logic [31:0] tgt);
    branch = b; branch_taken = bt; jump = j; jump_reg = jr; reg_target = tgt;
    stall = 1'b0;
    @(posedge clk); #1;
    branch = 0; branch_taken = 0; jump = 0; jump_reg = 0; reg_target = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    reset = 1'b0; stall = 0; branch = 0; branch_taken = 0; jump = 0; jump_reg = 0;
    reg_target = '0;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'h2001_0005;

    // 1: reset values, then back-to-back fetches with ack tied high
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_req", {31'b0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      e.pc = 32'(i * 4); e.ins = 32'h2001_0005;
      exp_addr_q.push_back(e.pc);
      exp_ins_q.push_back(e);
    end
    period_chk = 1'b1;
    reset = 1'b1;
    n = 0;
    while (exp_addr_q.size() != 0 && n < 30) begin
      @(posedge clk); #1; n++;
    end
    bus.imem_ack = 1'b0;
    period_chk = 1'b0;
    chk("t1_fetches_done", exp_addr_q.size(), 0);

    // 2: three cycles of ack latency, then a spurious ack while in EXEC
    serve(3, 32'h1234_5678, 32'h0000_000C);
    stall = 1'b1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    stall = 1'b0;
    chk("spur_instr", instruction, 32'h1234_5678);
    chk("spur_pc", pc, 32'h0000_000C);
    chk("spur_valid", {31'b0, instr_valid}, 32'd1);
    chk("spur_req", {31'b0, bus.imem_req}, 32'd0);

    // 3: conditional branch with offset -8 from pc 0x100
    exec(0, 0, 0, 1, 32'h0000_0100);
    serve(0, 32'h0000_FFF8, 32'h0000_0100);
    exec(1, 1, 0, 0, '0);
    serve(0, 32'h0000_0000, 32'h0000_00FC);
    exec(0, 0, 0, 1, 32'h0000_0100);
    serve(0, 32'h0000_FFF8, 32'h0000_0100);
    exec(1, 0, 0, 0, '0);
    serve(0, 32'h0000_0000, 32'h0000_0104);

    // 4: jump offset 0x40, then jump_reg priority over jump
    exec(0, 0, 0, 1, 32'h0000_0100);
    serve(0, 32'h0000_0040, 32'h0000_0100);
    exec(0, 0, 1, 0, '0);
    serve(0, 32'h0000_0040, 32'h0000_0144);
    exec(0, 0, 0, 1, 32'h0000_0100);
    serve(0, 32'h0000_0040, 32'h0000_0100);
    exec(1, 1, 1, 1, 32'h0000_2000);
    // negative 26-bit jump offset (-16): 0x2004 - 0x10
    serve(0, 32'h03FF_FFF0, 32'h0000_2000);
    exec(0, 0, 1, 0, '0);
    serve(0, 32'h0000_0000, 32'h0000_1FF4);

    // PC wrap at the top of the address space
    exec(0, 0, 0, 1, 32'hFFFF_FFFC);
    serve(0, 32'h0000_0000, 32'hFFFF_FFFC);
    exec(0, 0, 0, 0, '0);
    chk("wrap_fault", {31'b0, fetch_fault}, 32'd0);

    // 5: stall for 5 cycles overrides a pending redirect
    serve(0, 32'h0000_0010, 32'h0000_0000);
    stall = 1'b1; branch = 1'b1; branch_taken = 1'b1;
    jump_reg = 1'b1; reg_target = 32'h0000_3000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("stall_instr", instruction, 32'h0000_0010);
      chk("stall_pc", pc, 32'h0000_0000);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_req", {31'b0, bus.imem_req}, 32'd0);
    end
    jump_reg = 1'b0; reg_target = '0;
    exec(1, 1, 0, 0, '0);
    chk("stall_target", bus.imem_addr, 32'h0000_0014);
    serve(0, 32'h0000_0000, 32'h0000_0014);

    // 6: misaligned register target halts fetching
    exec(0, 0, 0, 1, 32'h0000_2002);
    chk("halt_fault", {31'b0, fetch_fault}, 32'd1);
    chk("halt_valid", {31'b0, instr_valid}, 32'd0);
    chk("halt_instr", instruction, 32'h0);
    bus.imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("halt_req", {31'b0, bus.imem_req}, 32'd0);
    end
    bus.imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst2_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst2_addr", bus.imem_addr, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    serve(0, 32'h0000_0011, 32'h0000_0000);

    // reset in the middle of a request, with a late ack while held in reset
    exec(0, 0, 0, 0, '0);
    wait_req();
    chk("midreq_addr", bus.imem_addr, 32'h0000_0004);
    #3 reset = 1'b0;
    #1;
    chk("midreq_drop", {31'b0, bus.imem_req}, 32'd0);
    @(posedge clk); #1;
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    chk("late_ack_valid", {31'b0, instr_valid}, 32'd0);
    reset = 1'b1;
    serve(0, 32'h0000_0022, 32'h0000_0000);

    repeat (2) @(posedge clk);
    #1;
    chk("addr_q_empty", exp_addr_q.size(), 0);
    chk("ins_q_empty", exp_ins_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the architectural PC and issues word fetches to instruction memory over a req/ack handshake.
- Holds the fetched instruction stable for decode.
- Computes the next PC from the decode stage's BRANCH/JUMP outputs, the branch condition, and the register operand.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0000, instruction value presented while no valid fetch is held.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- stall  in  1  downstream hold; freezes the held instruction and PC.
- branch  in  1  BRANCH from the decode stage, for the held instruction.
- branch_taken  in  1  branch condition result; 1 = taken.
- jump  in  1  JUMP from decode (J/JAL).
- jump_reg  in  1  register jump (JR/JALR).
- reg_target  in  32  OPERAND_A from decode; target for jump_reg.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch byte address.
- imem_ack  in  1  read data valid this cycle.
- imem_rdata  in  [0:31]  fetched word.
- instruction  out  [0:31]  held instruction to decode.
- instr_valid  out  1  instruction holds a real fetch.
- pc  out  32  address of the held instruction.
- pc_plus4  out  32  pc+4; link value for JAL/JALR.
- fetch_fault  out  1  sticky misaligned-target flag.

Behaviour:
- Reset (async, reset=0):
  - FSM=IDLE, fetch_pc=RESET_PC, pc=RESET_PC.
  - instruction=NOP_INSTR, instr_valid=0, imem_req=0, imem_addr=RESET_PC, fetch_fault=0.
- FSM states: IDLE, REQ, EXEC, HALT.
  - IDLE -> REQ unconditionally on the first clock after reset deasserts.
  - REQ:
    - imem_req=1 and imem_addr=fetch_pc, both held constant until ack.
    - On imem_ack: instruction<=imem_rdata, pc<=fetch_pc, instr_valid<=1, go to EXEC.
    - The instruction is visible the cycle after ack.
  - EXEC:
    - imem_req=0. Control inputs refer to the held instruction.
    - If stall=1: hold all state.
    - Else:
      - Compute next_pc and check alignment.
      - If next_pc[1:0]!=0: fetch_fault<=1, instr_valid<=0, instruction<=NOP_INSTR, go to HALT.
      - Otherwise: fetch_pc<=next_pc, instr_valid<=0, instruction<=NOP_INSTR, go to REQ.
  - HALT: terminal. imem_req=0, instr_valid=0. Only reset exits.
- next_pc priority (all arithmetic 32-bit, wraps modulo 2^32):
  1. jump_reg=1: reg_target.
  2. jump=1: pc_plus4 + sign-extended instruction[6:31] (26-bit byte offset).
  3. branch=1 and branch_taken=1: pc_plus4 + sign-extended instruction[16:31].
  4. Otherwise: pc_plus4.
- Throughput: minimum 2 cycles per instruction (one REQ cycle with immediate ack, one EXEC cycle). Each extra ack-latency cycle adds one.
- imem_ack outside REQ is ignored. This includes a late ack for a request killed by reset.
- pc_plus4 is combinational from pc.
- Simultaneous events:
  - Active stall overrides redirect; the redirect is evaluated on the first non-stalled EXEC cycle using the inputs at that cycle.
  - stall has no effect in REQ.
- Reset mid-REQ: request drops immediately (async); the fetch restarts at RESET_PC after IDLE.
- PC wrap: 0xFFFF_FFFC + 4 = 0x0000_0000, with no fault.

Test Plan:
1. Reset, imem_ack tied 1, imem_rdata=0x2001_0005:
   - instr_valid=0 and instruction=NOP_INSTR during reset.
   - First request at address 0x0.
   - Fetch addresses 0x0, 0x4, 0x8 on a 2-cycle period.
   - pc_plus4 = pc+4 for each fetch.
2. Ack latency 3 cycles:
   - imem_req and imem_addr stable for 4 cycles.
   - instruction appears the cycle after ack.
   - A spurious ack while in EXEC is ignored.
3. pc=0x100, instruction[16:31]=0xFFF8, branch=1:
   - branch_taken=1: next fetch address 0xFC.
   - branch_taken=0: next fetch address 0x104.
4. pc=0x100, jump=1, offset field 0x40 -> next fetch address 0x144. Same cycle with jump_reg=1, reg_target=0x2000 -> 0x2000 (priority).
5. stall held 5 cycles in EXEC with branch taken:
   - instruction, pc and instr_valid frozen; no request issued.
   - After release, fetch at the branch target.
6. jump_reg=1, reg_target=0x2002:
   - fetch_fault=1, FSM in HALT, no further imem_req.
   - Async reset clears fetch_fault and fetch resumes at RESET_PC. Reset asserted mid-REQ drops imem_req in the same cycle.
